// File: rtl/multi_packet_input_buffer_pkg.sv
// Shared NoC flit/port types and helpers for the per-VC input buffer.
package multi_packet_input_buffer_pkg;
  localparam int unsigned VC_NUM  = 4;
  localparam int unsigned VC_SIZE = $clog2(VC_NUM);
  localparam int unsigned DATA_W  = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
  typedef enum logic [1:0] {IDLE, VA, SA} ib_state_t;

  typedef struct packed {
    flit_label_t         flit_label;
    logic [VC_SIZE-1:0]  vc_id;
    logic [DATA_W-1:0]   data;
  } flit_t;

  function automatic logic is_head(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction
endpackage

// File: rtl/multi_packet_input_buffer_circular_buffer.sv
// Circular flit store with occupancy count and on/off flow-control indication.
module circular_buffer
  import multi_packet_input_buffer_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE    = 8,
  parameter int unsigned PIPELINE_DEPTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  flit_t                            data_i,
  input  logic                             read_i,
  input  logic                             write_i,
  output flit_t                            data_o,
  output logic                             is_full_o,
  output logic                             is_empty_o,
  output logic                             on_off_o,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] occupancy_o
);
  localparam int unsigned PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE+1);
  // "on" while free slots exceed the in-flight margin of the upstream pipeline
  localparam int unsigned ON_LIMIT = (BUFFER_SIZE > PIPELINE_DEPTH) ? BUFFER_SIZE - PIPELINE_DEPTH : 0;

  flit_t            mem_q [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_read, do_write;

  always_comb begin
    do_read  = read_i && (count_q != '0);
    do_write = write_i && (count_q != CNT_W'(BUFFER_SIZE));
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_read)
      rd_ptr_d = (rd_ptr_q == PTR_W'(BUFFER_SIZE-1)) ? '0 : rd_ptr_q + 1'b1;
    if (do_write)
      wr_ptr_d = (wr_ptr_q == PTR_W'(BUFFER_SIZE-1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_write && !do_read)
      count_d = count_q + 1'b1;
    else if (!do_write && do_read)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write)
      mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o      = mem_q[rd_ptr_q];
  assign is_full_o   = (count_q == CNT_W'(BUFFER_SIZE));
  assign is_empty_o  = (count_q == '0);
  assign on_off_o    = (count_q < CNT_W'(ON_LIMIT));
  assign occupancy_o = count_q;
endmodule

// File: rtl/multi_packet_input_buffer.sv
// Per-VC router input buffer: multi-packet flit queue, per-packet route FIFO and VA/SA head FSM.
module multi_packet_input_buffer
  import multi_packet_input_buffer_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE    = 8,
  parameter int unsigned PIPELINE_DEPTH = 5,
  parameter int unsigned MAX_PACKETS    = 4,
  parameter bit          ATOMIC         = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  flit_t                            data_i,
  input  logic                             write_i,
  input  port_t                            out_port_i,
  input  logic                             read_i,
  input  logic [VC_SIZE-1:0]               vc_new_i,
  input  logic                             vc_valid_i,
  output flit_t                            data_o,
  output port_t                            out_port_o,
  output logic [VC_SIZE-1:0]               downstream_vc_o,
  output logic                             vc_request_o,
  output logic                             switch_request_o,
  output logic                             vc_allocatable_o,
  output logic                             credit_o,
  output logic                             is_full_o,
  output logic                             is_empty_o,
  output logic                             on_off_o,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] occupancy_o,
  output logic [$clog2(MAX_PACKETS+1)-1:0] pkt_count_o,
  output logic                             error_o
);
  localparam int unsigned RF_DEPTH = ATOMIC ? 1 : MAX_PACKETS;
  localparam int unsigned RP_W     = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
  localparam int unsigned RC_W     = $clog2(RF_DEPTH+1);
  localparam int unsigned PKT_W    = $clog2(MAX_PACKETS+1);

  ib_state_t           state_q, state_d;
  port_t               route_q [RF_DEPTH];
  logic [RP_W-1:0]     rf_rd_q, rf_rd_d, rf_wr_q, rf_wr_d;
  logic [RC_W-1:0]     rf_cnt_q, rf_cnt_d;
  port_t               out_port_q, out_port_d;
  logic [VC_SIZE-1:0]  dvc_q, dvc_d;
  logic [PKT_W-1:0]    pkt_q, pkt_d;
  logic                in_pkt_q, in_pkt_d;
  logic                credit_q, alloc_q, err_q;
  logic                w_head, head_ok, write_acc, read_acc, tail_out;
  logic                rf_full, rf_empty, rf_push, rf_pop, bypass;
  flit_t               buf_data;

  circular_buffer #(
    .BUFFER_SIZE   (BUFFER_SIZE),
    .PIPELINE_DEPTH(PIPELINE_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .read_i     (read_acc),
    .write_i    (write_acc),
    .data_o     (buf_data),
    .is_full_o  (is_full_o),
    .is_empty_o (is_empty_o),
    .on_off_o   (on_off_o),
    .occupancy_o(occupancy_o)
  );

  always_comb begin
    w_head    = is_head(data_i.flit_label);
    rf_full   = (rf_cnt_q == RC_W'(RF_DEPTH));
    rf_empty  = (rf_cnt_q == '0);
    head_ok   = !in_pkt_q && !is_full_o && !rf_full;
    if (ATOMIC)
      head_ok = head_ok && is_empty_o && (state_q == IDLE);
    write_acc = write_i && (w_head ? head_ok : (in_pkt_q && !is_full_o));
    read_acc  = read_i && (state_q == SA) && !is_empty_o;
    tail_out  = read_acc && is_tail(buf_data.flit_label);
  end

  // A head arriving while the FIFO is empty in IDLE takes its route straight into
  // out_port; it is not also pushed, so it cannot be popped a second time later.
  always_comb begin
    state_d          = state_q;
    out_port_d       = out_port_q;
    dvc_d            = dvc_q;
    rf_pop           = 1'b0;
    bypass           = 1'b0;
    vc_request_o     = 1'b0;
    switch_request_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rf_empty) begin
          state_d    = VA;
          out_port_d = route_q[rf_rd_q];
          rf_pop     = 1'b1;
        end else if (write_acc && w_head) begin
          state_d    = VA;
          out_port_d = out_port_i;
          bypass     = 1'b1;
        end
      end
      VA: begin
        vc_request_o = 1'b1;
        if (vc_valid_i) begin
          state_d = SA;
          dvc_d   = vc_new_i;
        end
      end
      SA: begin
        switch_request_o = !is_empty_o;
        if (tail_out)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_push  = write_acc && w_head && !bypass;
    rf_rd_d  = rf_rd_q;
    rf_wr_d  = rf_wr_q;
    rf_cnt_d = rf_cnt_q;
    if (rf_pop)
      rf_rd_d = (rf_rd_q == RP_W'(RF_DEPTH-1)) ? '0 : rf_rd_q + 1'b1;
    if (rf_push)
      rf_wr_d = (rf_wr_q == RP_W'(RF_DEPTH-1)) ? '0 : rf_wr_q + 1'b1;
    if (rf_push && !rf_pop)
      rf_cnt_d = rf_cnt_q + 1'b1;
    else if (!rf_push && rf_pop)
      rf_cnt_d = rf_cnt_q - 1'b1;

    pkt_d = pkt_q;
    if ((write_acc && w_head) && !tail_out)
      pkt_d = pkt_q + 1'b1;
    else if (!(write_acc && w_head) && tail_out)
      pkt_d = pkt_q - 1'b1;

    in_pkt_d = in_pkt_q;
    if (write_acc && (data_i.flit_label == HEAD))
      in_pkt_d = 1'b1;
    else if (write_acc && (data_i.flit_label == TAIL))
      in_pkt_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rf_rd_q    <= '0;
      rf_wr_q    <= '0;
      rf_cnt_q   <= '0;
      out_port_q <= LOCAL;
      dvc_q      <= '0;
      pkt_q      <= '0;
      in_pkt_q   <= 1'b0;
      credit_q   <= 1'b0;
      alloc_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_rd_q    <= rf_rd_d;
      rf_wr_q    <= rf_wr_d;
      rf_cnt_q   <= rf_cnt_d;
      out_port_q <= out_port_d;
      dvc_q      <= dvc_d;
      pkt_q      <= pkt_d;
      in_pkt_q   <= in_pkt_d;
      credit_q   <= read_acc;
      alloc_q    <= tail_out;
      err_q      <= (write_i && !write_acc) || (read_i && !read_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (rf_push)
      route_q[rf_wr_q] <= out_port_i;
  end

  always_comb begin
    data_o       = buf_data;
    data_o.vc_id = dvc_q;
  end

  assign out_port_o       = out_port_q;
  assign downstream_vc_o  = dvc_q;
  assign vc_allocatable_o = alloc_q;
  assign credit_o         = credit_q;
  assign pkt_count_o      = pkt_q;
  assign error_o          = err_q;
endmodule
